// File: rtl/vec_issue_sequencer.sv
// Fetch/issue controller for the CGRA vector core.
// Walks a word-addressed PC through a synchronous instruction ROM, shows each
// instruction to the decoder for exactly one cycle, acts on the decode flags,
// and stalls issue while a vector op streams its VL elements through the datapath.
module vec_issue_sequencer #(
    parameter int dwidth_inst = 32,
    parameter int PC_WIDTH    = 10,
    parameter int VL_WIDTH    = 8,
    parameter int MAX_VL      = 16,
    parameter logic [dwidth_inst-1:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [dwidth_inst-1:0] imem_rdata,
    output logic [dwidth_inst-1:0] instr,
    output logic                   instr_valid,
    input  logic                   is_not_vect,
    input  logic                   is_bne,
    input  logic                   branch_taken,
    input  logic [11:0]            branch_immediate,
    input  logic                   is_csr,
    input  logic [VL_WIDTH-1:0]    vl_imm,
    input  logic                   dp_ready,
    output logic                   vec_busy,
    output logic [VL_WIDTH-1:0]    vec_elem_idx,
    output logic [VL_WIDTH-1:0]    vl,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_VEXEC = 2'd3;

    localparam logic [VL_WIDTH-1:0] MAX_VL_V = VL_WIDTH'(MAX_VL);
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
    localparam logic [VL_WIDTH-1:0] VL_ONE   = VL_WIDTH'(1);

    logic [1:0]          state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic [VL_WIDTH-1:0] vl_q, vl_nxt;
    logic [VL_WIDTH-1:0] idx_q, idx_nxt;

    logic                   issuing;
    logic                   is_halt;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH+10:0]   br_sext;
    logic [PC_WIDTH-1:0]    br_off;
    logic [VL_WIDTH-1:0]    vl_clamped;

    // The decoder's immediate is in half-words; dropping bit 0 gives a word
    // offset, which is sign-extended and then folded to PC width so that the
    // PC addition wraps naturally.
    assign br_sext    = {{PC_WIDTH{branch_immediate[11]}}, branch_immediate[11:1]};
    assign br_off     = br_sext[PC_WIDTH-1:0];
    assign pc_inc     = pc + PC_ONE;
    assign vl_clamped = (vl_imm > MAX_VL_V) ? MAX_VL_V : vl_imm;

    // Outputs are decoded straight from state so an async reset clears them at once.
    assign issuing      = (state == S_ISSUE);
    assign is_halt      = (imem_rdata == HALT_INSTR);
    assign imem_addr    = pc;
    assign instr        = issuing ? imem_rdata : '0;
    assign instr_valid  = issuing;
    assign done         = issuing && is_halt;
    assign vec_busy     = (state == S_VEXEC);
    assign busy         = (state != S_IDLE);
    assign vl           = vl_q;
    assign vec_elem_idx = idx_q;

    // Next-state, PC, VL and element-counter selection for the issue FSM.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        vl_nxt    = vl_q;
        idx_nxt   = idx_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                    idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (is_halt) begin
                    state_nxt = S_IDLE;
                end else if (is_csr) begin
                    vl_nxt    = vl_clamped;
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end else if (is_bne) begin
                    pc_nxt    = branch_taken ? (pc + br_off) : pc_inc;
                    state_nxt = S_FETCH;
                end else if (!is_not_vect && (vl_q != '0)) begin
                    idx_nxt   = '0;
                    state_nxt = S_VEXEC;
                end else begin
                    pc_nxt    = pc_inc;
                    state_nxt = S_FETCH;
                end
            end
            S_VEXEC: begin
                if (dp_ready) begin
                    if (idx_q == (vl_q - VL_ONE)) begin
                        idx_nxt   = '0;
                        pc_nxt    = pc_inc;
                        state_nxt = S_FETCH;
                    end else begin
                        idx_nxt = idx_q + VL_ONE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight vector op and restores VL to its ceiling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= '0;
            vl_q  <= MAX_VL_V;
            idx_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            vl_q  <= vl_nxt;
            idx_q <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Testbench for vec_issue_sequencer.
// Plays the instruction ROM, the decoder and the datapath. A program-level model
// walks each ROM program and lists, cycle by cycle, what the sequencer must show.
module tb_vec_issue_sequencer;

    localparam logic [31:0] HALT = 32'h0000_0073;
    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] LUI  = 32'h0000_10b7;
    localparam logic [31:0] LW   = 32'h0000_a103;
    localparam logic [31:0] VALU = 32'h0231_0257;
    localparam int MAXT = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        is_not_vect;
    logic        is_bne;
    logic        branch_taken;
    logic [11:0] branch_immediate;
    logic        is_csr;
    logic [7:0]  vl_imm;
    logic        dp_ready;
    logic        vec_busy;
    logic [7:0]  vec_elem_idx;
    logic [7:0]  vl;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic        nv;
        logic        bne;
        logic        csr;
        logic [11:0] bimm;
        logic [7:0]  vimm;
    } dec_t;

    typedef struct {
        int addr;
        int valid;
        logic [31:0] ins;
        int vb;
        int idx;
        int vlen;
        int dn;
    } rec_t;

    logic [31:0] rom [1024];
    logic        taken_seq [64];
    logic        rdy [MAXT];
    int          br_idx = 0;
    rec_t        trace [$];
    int          mvl;
    int          overflow;
    int          total = 0;
    int          bad = 0;
    dec_t        dcur;

    vec_issue_sequencer dut (
        .clk(clk), .rst(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .is_not_vect(is_not_vect), .is_bne(is_bne), .branch_taken(branch_taken),
        .branch_immediate(branch_immediate), .is_csr(is_csr), .vl_imm(vl_imm),
        .dp_ready(dp_ready), .vec_busy(vec_busy), .vec_elem_idx(vec_elem_idx),
        .vl(vl), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bench instruction encodings: OP-V with funct3=111 is vsetivli (AVL in [27:20]),
    // other OP-V is a vector ALU op, BRANCH carries imm[12:1] in [31:20].
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d = '{nv: 1'b1, bne: 1'b0, csr: 1'b0, bimm: 12'h0, vimm: 8'h0};
        if (w[6:0] == 7'b1010111) begin
            d.nv = 1'b0;
            if (w[14:12] == 3'b111) begin
                d.csr  = 1'b1;
                d.vimm = w[27:20];
            end
        end else if (w[6:0] == 7'b1100011) begin
            d.bne  = 1'b1;
            d.bimm = w[31:20];
        end
        return d;
    endfunction

    function automatic logic [31:0] vset(input int n);
        logic [7:0] a;
        a = 8'(n);
        return {4'b1100, a, 5'd0, 3'b111, 5'd1, 7'b1010111};
    endfunction

    function automatic logic [31:0] bne_w(input int words);
        logic [11:0] im;
        im = 12'(words * 2);
        return {im, 5'd2, 3'b001, 5'd0, 7'b1100011};
    endfunction

    // Synchronous ROM: one-cycle read latency.
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    // Decoder stand-in driven by whatever the sequencer presents.
    always_comb begin
        dcur = decode(instr);
    end
    assign is_not_vect      = dcur.nv;
    assign is_bne           = dcur.bne;
    assign is_csr           = dcur.csr;
    assign branch_immediate = dcur.bimm;
    assign vl_imm           = dcur.vimm;
    assign branch_taken     = (dcur.bne && br_idx < 64) ? taken_seq[br_idx] : 1'b0;

    // Each issued branch consumes the next compare result of the current run.
    always @(posedge clk) begin
        if (start && !busy) br_idx <= 0;
        else if (instr_valid && is_bne) br_idx <= br_idx + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program-level model: run the ROM program and list the expected per-cycle view.
    task automatic build_trace();
        int pc, bi, e, off;
        logic [31:0] w;
        dec_t d;
        trace.delete();
        overflow = 0;
        pc = 0;
        bi = 0;
        forever begin
            if (trace.size() > MAXT - 40) begin
                overflow = 1;
                break;
            end
            w = rom[pc];
            d = decode(w);
            trace.push_back('{pc, 0, 32'h0, 0, 0, mvl, 0});
            trace.push_back('{pc, 1, w, 0, 0, mvl, (w == HALT) ? 1 : 0});
            if (w == HALT) break;
            if (d.csr) begin
                mvl = (d.vimm > 16) ? 16 : int'(d.vimm);
                pc = pc + 1;
            end else if (d.bne) begin
                off = int'($signed(d.bimm[11:1]));
                if (bi < 64 && taken_seq[bi]) pc = pc + off;
                else pc = pc + 1;
                bi++;
            end else if (!d.nv && mvl != 0) begin
                e = 0;
                while (e < mvl && trace.size() < MAXT - 40) begin
                    trace.push_back('{pc, 0, 32'h0, 1, e, mvl, 0});
                    if (rdy[trace.size() - 1]) e++;
                end
                pc = pc + 1;
            end else begin
                pc = pc + 1;
            end
            pc = pc & 1023;
        end
    endtask

    task automatic check_output(input string name, input int k, input rec_t r);
        chk($sformatf("%s[%0d].addr", name, k), 32'(imem_addr), r.addr);
        chk($sformatf("%s[%0d].valid", name, k), 32'(instr_valid), r.valid);
        chk($sformatf("%s[%0d].instr", name, k), instr, r.ins);
        chk($sformatf("%s[%0d].vec_busy", name, k), 32'(vec_busy), r.vb);
        chk($sformatf("%s[%0d].idx", name, k), 32'(vec_elem_idx), r.idx);
        chk($sformatf("%s[%0d].vl", name, k), 32'(vl), r.vlen);
        chk($sformatf("%s[%0d].done", name, k), 32'(done), r.dn);
        chk($sformatf("%s[%0d].busy", name, k), 32'(busy), 1);
    endtask

    // Start a program, follow it cycle by cycle, then confirm the return to idle.
    // restart_at >= 0 re-pulses start during that cycle, which must be ignored.
    task automatic apply_stimulus(input string name, input int restart_at);
        build_trace();
        chk({name, ".model_bound"}, 32'(overflow), 0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < trace.size(); k++) begin
            dp_ready = rdy[k];
            if (k == restart_at) start = 1'b1;
            @(negedge clk);
            check_output(name, k, trace[k]);
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        chk({name, ".idle_busy"}, 32'(busy), 0);
        chk({name, ".idle_valid"}, 32'(instr_valid), 0);
        chk({name, ".idle_done"}, 32'(done), 0);
        chk({name, ".idle_vl"}, 32'(vl), mvl);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) rom[i] = HALT;
        for (int i = 0; i < 64; i++) taken_seq[i] = 1'b0;
        for (int i = 0; i < MAXT; i++) rdy[i] = 1'b1;
    endtask

    initial begin
        int found;
        int r;
        start    = 1'b0;
        dp_ready = 1'b0;
        rst_n    = 1'b0;
        mvl      = 16;
        clear_prog();
        #12;
        chk("reset.busy", 32'(busy), 0);
        chk("reset.vl", 32'(vl), 16);
        chk("reset.addr", 32'(imem_addr), 0);
        chk("reset.instr", instr, 0);
        chk("reset.vec_busy", 32'(vec_busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] scalar program");
        rom[0] = ADDI; rom[1] = LUI; rom[2] = LW; rom[3] = HALT;
        apply_stimulus("scalar", -1);

        $display("[TB] vsetivli and vector op");
        clear_prog();
        rom[0] = vset(4); rom[1] = VALU; rom[2] = vset(40); rom[3] = VALU;
        apply_stimulus("vset", -1);

        $display("[TB] backpressure");
        clear_prog();
        rom[0] = vset(4); rom[1] = VALU;
        for (int i = 0; i < MAXT; i++) rdy[i] = (i % 2 == 1);
        apply_stimulus("bp", -1);

        $display("[TB] branches");
        clear_prog();
        rom[0] = ADDI; rom[1] = ADDI; rom[2] = LUI; rom[3] = ADDI; rom[4] = LW;
        rom[5] = bne_w(-4);
        taken_seq[0] = 1'b1;
        apply_stimulus("bne", -1);

        clear_prog();
        rom[0] = bne_w(-2); rom[1022] = ADDI; rom[1023] = LUI;
        taken_seq[0] = 1'b1;
        apply_stimulus("wrap", -1);

        $display("[TB] corners");
        clear_prog();
        rom[0] = vset(0); rom[1] = VALU; rom[2] = ADDI; rom[3] = vset(3); rom[4] = VALU;
        apply_stimulus("vl0", 3);

        $display("[TB] random programs");
        for (int p = 0; p < 6; p++) begin
            clear_prog();
            for (int i = 0; i < 20; i++) begin
                r = $urandom_range(0, 9);
                if (r < 2) rom[i] = ADDI;
                else if (r < 3) rom[i] = LUI;
                else if (r < 4) rom[i] = LW;
                else if (r < 6) rom[i] = vset($urandom_range(0, 40));
                else if (r < 8) rom[i] = VALU;
                else if ($urandom_range(0, 2) != 0) rom[i] = bne_w($urandom_range(1, 6));
                else rom[i] = bne_w(-$urandom_range(1, 3));
            end
            for (int i = 0; i < 6; i++) taken_seq[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < MAXT; i++) rdy[i] = ($urandom_range(0, 9) < 7);
            apply_stimulus($sformatf("rand%0d", p), -1);
        end

        $display("[TB] reset during vector op");
        clear_prog();
        rom[0] = vset(8); rom[1] = VALU;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dp_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (vec_busy) found = 1;
        end
        chk("rst_mid.reached_vexec", 32'(found), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mvl = 16;
        chk("rst_mid.vec_busy", 32'(vec_busy), 0);
        chk("rst_mid.busy", 32'(busy), 0);
        chk("rst_mid.vl", 32'(vl), 16);
        chk("rst_mid.idx", 32'(vec_elem_idx), 0);
        chk("rst_mid.addr", 32'(imem_addr), 0);
        chk("rst_mid.valid", 32'(instr_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.stays_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
